// File: rtl/jam_pkg.sv
// Shared types and helpers for the permutation search: FSM states, index width
// function, permutation pack helpers and the worker-count legality check.
package jam_pkg;

    localparam int MAX_N  = 8;
    localparam int MAX_IW = 3;
    localparam int VEC_W  = MAX_N * MAX_IW;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        PIVOT,
        SWAP,
        REVERSE,
        DONE
    } state_t;

    typedef logic [MAX_IW-1:0] slot_t;
    typedef slot_t [MAX_N-1:0] perm_t;

    function automatic int clog2_min1(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit n_work_legal(input int n);
        return (n >= 2) && (n <= MAX_N);
    endfunction

    function automatic perm_t identity_perm();
        perm_t p;
        for (int i = 0; i < MAX_N; i++) p[i] = slot_t'(i);
        return p;
    endfunction

    // Slot i lands at bit i*iw; slots at or beyond n are left out.
    function automatic logic [VEC_W-1:0] pack_perm(input perm_t p, input int n, input int iw);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) v = v | (VEC_W'(p[i]) << (i * iw));
        end
        return v;
    endfunction

    function automatic perm_t unpack_perm(input logic [VEC_W-1:0] v, input int n, input int iw);
        perm_t p;
        for (int i = 0; i < MAX_N; i++) begin
            p[i] = (i < n) ? slot_t'((v >> (i * iw)) & VEC_W'((1 << iw) - 1)) : slot_t'(i);
        end
        return p;
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Holds the current permutation and steps it to its lexicographic successor
// (pivot scan, swap scan, tail reversal, one element per cycle); step_done pulses at the end.
module jam_next_perm
    import jam_pkg::*;
#(
    parameter int N_WORK = 8,
    parameter int IDX_W  = clog2_min1(N_WORK)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    init,
    input  logic                    step_req,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [IDX_W-1:0]        rd_job,
    output logic [N_WORK*IDX_W-1:0] perm_vec,
    output logic                    step_done,
    output logic                    last
);

    localparam slot_t LAST_IX = slot_t'(N_WORK - 1);

    state_t           phase, phase_nx;
    perm_t            perm, perm_nx;
    slot_t            k, k_nx, j, j_nx, h, h_nx, t, t_nx;
    logic [VEC_W-1:0] packed_all;

    assign rd_job     = perm[slot_t'(rd_idx)][IDX_W-1:0];
    assign packed_all = pack_perm(perm, N_WORK, IDX_W);
    assign perm_vec   = packed_all[N_WORK*IDX_W-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase <= IDLE;
            perm  <= identity_perm();
            k     <= '0;
            j     <= '0;
            h     <= '0;
            t     <= '0;
        end else begin
            phase <= phase_nx;
            perm  <= perm_nx;
            k     <= k_nx;
            j     <= j_nx;
            h     <= h_nx;
            t     <= t_nx;
        end
    end

    always_comb begin
        phase_nx  = phase;
        perm_nx   = perm;
        k_nx      = k;
        j_nx      = j;
        h_nx      = h;
        t_nx      = t;
        step_done = 1'b0;
        last      = 1'b0;
        case (phase)
            IDLE: begin
                if (init) begin
                    perm_nx = identity_perm();
                end else if (step_req) begin
                    phase_nx = PIVOT;
                    k_nx     = LAST_IX - 1'b1;
                end
            end
            PIVOT: begin
                if (perm[k] < perm[k + 1'b1]) begin
                    phase_nx = SWAP;
                    j_nx     = LAST_IX;
                end else if (k == '0) begin
                    // Fully descending: this was the final permutation.
                    phase_nx  = IDLE;
                    step_done = 1'b1;
                    last      = 1'b1;
                end else begin
                    k_nx = k - 1'b1;
                end
            end
            SWAP: begin
                if (perm[j] > perm[k]) begin
                    perm_nx[j] = perm[k];
                    perm_nx[k] = perm[j];
                    phase_nx   = REVERSE;
                    h_nx       = k + 1'b1;
                    t_nx       = LAST_IX;
                end else begin
                    j_nx = j - 1'b1;
                end
            end
            REVERSE: begin
                if (h < t) begin
                    perm_nx[h] = perm[t];
                    perm_nx[t] = perm[h];
                    h_nx       = h + 1'b1;
                    t_nx       = t - 1'b1;
                end else begin
                    phase_nx  = IDLE;
                    step_done = 1'b1;
                end
            end
            default: phase_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/jam_perm_search.sv
// Exhaustive assignment search: min total cost, tie count and first optimal permutation.
// Results one pulse of Valid after ~N!*(N+~N) cycles; Start ignored while Busy. Option JAM_PRUNE_EN.
module jam_perm_search
    import jam_pkg::*;
#(
    parameter  int N_WORK = 8,
    parameter  int COST_W = 7,
    parameter  int CNT_W  = 16,
    localparam int IDX_W  = clog2_min1(N_WORK),
    localparam int SUM_W  = COST_W + IDX_W + 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    Start,
    output logic                    Busy,
    output logic [IDX_W-1:0]        W,
    output logic [IDX_W-1:0]        J,
    input  logic [COST_W-1:0]       Cost,
    output logic                    Valid,
    output logic [SUM_W-1:0]        MinCost,
    output logic [CNT_W-1:0]        MatchCount,
    output logic [N_WORK*IDX_W-1:0] BestJob
);

    if (!n_work_legal(N_WORK)) begin : g_bad_n_work
        $error("jam_perm_search: N_WORK must lie in 2..8");
    end

    localparam logic [VEC_W-1:0] ID_ALL = pack_perm(identity_perm(), N_WORK, IDX_W);

    state_t                    state, state_nx;
    logic [IDX_W-1:0]          rd_idx, rd_idx_nx;
    logic [SUM_W-1:0]          acc, acc_nx, best, best_nx, acc_sum, min_nx;
    logic [CNT_W-1:0]          count, count_nx, match_nx;
    logic [N_WORK*IDX_W-1:0]   bestjob_nx, perm_vec;
    logic                      init, step_req, step_done, last, prune;

    jam_next_perm #(.N_WORK(N_WORK), .IDX_W(IDX_W)) u_step (
        .CLK       (CLK),
        .RST       (RST),
        .init      (init),
        .step_req  (step_req),
        .rd_idx    (W),
        .rd_job    (J),
        .perm_vec  (perm_vec),
        .step_done (step_done),
        .last      (last)
    );

    assign acc_sum = acc + SUM_W'(Cost);
    assign Busy    = (state != IDLE);
    assign Valid   = (state == DONE);
    assign W       = (state == READ) ? rd_idx : '0;

`ifdef JAM_PRUNE_EN
    // Strictly greater only: a partial sum equal to best may still tie.
    assign prune = (acc_sum > best);
`else
    assign prune = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            rd_idx     <= '0;
            acc        <= '0;
            best       <= '0;
            count      <= '0;
            MinCost    <= '0;
            MatchCount <= '0;
            BestJob    <= ID_ALL[N_WORK*IDX_W-1:0];
        end else begin
            state      <= state_nx;
            rd_idx     <= rd_idx_nx;
            acc        <= acc_nx;
            best       <= best_nx;
            count      <= count_nx;
            MinCost    <= min_nx;
            MatchCount <= match_nx;
            BestJob    <= bestjob_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        rd_idx_nx  = rd_idx;
        acc_nx     = acc;
        best_nx    = best;
        count_nx   = count;
        min_nx     = MinCost;
        match_nx   = MatchCount;
        bestjob_nx = BestJob;
        init       = 1'b0;
        step_req   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    init      = 1'b1;
                    acc_nx    = '0;
                    best_nx   = '1;
                    count_nx  = '0;
                    rd_idx_nx = '0;
                    state_nx  = READ;
                end
            end
            READ: begin
                acc_nx = acc_sum;
                if (prune) begin
                    rd_idx_nx = '0;
                    step_req  = 1'b1;
                    state_nx  = PIVOT;
                end else if (rd_idx == IDX_W'(N_WORK - 1)) begin
                    rd_idx_nx = '0;
                    state_nx  = EVAL;
                end else begin
                    rd_idx_nx = rd_idx + 1'b1;
                end
            end
            EVAL: begin
                if (acc < best) begin
                    best_nx    = acc;
                    count_nx   = CNT_W'(1);
                    bestjob_nx = perm_vec;
                end else if ((acc == best) && (count != '1)) begin
                    count_nx = count + 1'b1;
                end
                step_req = 1'b1;
                state_nx = PIVOT;
            end
            // PIVOT here covers the whole successor step run by u_step.
            PIVOT: begin
                if (step_done) begin
                    if (last) begin
                        min_nx   = best;
                        match_nx = count;
                        state_nx = DONE;
                    end else begin
                        acc_nx   = '0;
                        state_nx = READ;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jam_perm_search.sv
// Directed bench: six search instances (N=2..5) with hand-computed cost tables and results.
module tb_jam_perm_search;
    import jam_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  start;
    logic        mode3;
    logic [5:0]  busy, valid, rdlast;
    logic [31:0] mc [6];
    logic [31:0] mt [6];
    logic [31:0] bj [6];
    logic [31:0] wv [6];
    logic [31:0] jv [6];
    logic [31:0] exp_id [6];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    logic [1:0] w0, j0, w1, j1, w2, j2, w4, j4;
    logic [2:0] w3, j3;
    logic       w5, j5;
    logic [6:0] c0, c1, c2, c3, c4, c5;
    logic [9:0] min0, min1, min2, min4;
    logic [10:0] min3;
    logic [8:0] min5;
    logic [15:0] cnt0, cnt1, cnt2, cnt3, cnt5;
    logic [3:0] cnt4;
    logic [5:0] bj0;
    logic [7:0] bj1, bj2, bj4;
    logic [14:0] bj3;
    logic [1:0] bj5;

    function automatic logic [6:0] m3(input logic [1:0] w, input logic [1:0] j);
        case ({w, j})
            4'h0: return 7'd4;
            4'h1: return 7'd1;
            4'h2: return 7'd2;
            4'h4: return 7'd1;
            4'h5: return 7'd3;
            4'h6: return 7'd1;
            4'h8: return 7'd2;
            4'h9: return 7'd1;
            4'hA: return 7'd5;
            default: return 7'd0;
        endcase
    endfunction

    always_comb begin
        c0 = mode3 ? m3(w0, j0) : 7'd1;
        c1 = (w1 == j1) ? 7'd0 : 7'd5;
        c2 = (j2 == (2'd3 - w2)) ? 7'd0 : 7'd9;
        c3 = 7'd127;
        c4 = 7'd2;
        c5 = (w5 == j5) ? 7'd3 : 7'd1;
    end

    jam_perm_search #(.N_WORK(3)) dut0 (.CLK(clk), .RST(rst), .Start(start[0]), .Busy(busy[0]),
        .W(w0), .J(j0), .Cost(c0), .Valid(valid[0]), .MinCost(min0), .MatchCount(cnt0), .BestJob(bj0));
    jam_perm_search #(.N_WORK(4)) dut1 (.CLK(clk), .RST(rst), .Start(start[1]), .Busy(busy[1]),
        .W(w1), .J(j1), .Cost(c1), .Valid(valid[1]), .MinCost(min1), .MatchCount(cnt1), .BestJob(bj1));
    jam_perm_search #(.N_WORK(4)) dut2 (.CLK(clk), .RST(rst), .Start(start[2]), .Busy(busy[2]),
        .W(w2), .J(j2), .Cost(c2), .Valid(valid[2]), .MinCost(min2), .MatchCount(cnt2), .BestJob(bj2));
    jam_perm_search #(.N_WORK(5)) dut3 (.CLK(clk), .RST(rst), .Start(start[3]), .Busy(busy[3]),
        .W(w3), .J(j3), .Cost(c3), .Valid(valid[3]), .MinCost(min3), .MatchCount(cnt3), .BestJob(bj3));
    jam_perm_search #(.N_WORK(4), .CNT_W(4)) dut4 (.CLK(clk), .RST(rst), .Start(start[4]), .Busy(busy[4]),
        .W(w4), .J(j4), .Cost(c4), .Valid(valid[4]), .MinCost(min4), .MatchCount(cnt4), .BestJob(bj4));
    jam_perm_search #(.N_WORK(2)) dut5 (.CLK(clk), .RST(rst), .Start(start[5]), .Busy(busy[5]),
        .W(w5), .J(j5), .Cost(c5), .Valid(valid[5]), .MinCost(min5), .MatchCount(cnt5), .BestJob(bj5));

    assign mc[0] = 32'(min0);  assign mt[0] = 32'(cnt0);  assign bj[0] = 32'(bj0);
    assign mc[1] = 32'(min1);  assign mt[1] = 32'(cnt1);  assign bj[1] = 32'(bj1);
    assign mc[2] = 32'(min2);  assign mt[2] = 32'(cnt2);  assign bj[2] = 32'(bj2);
    assign mc[3] = 32'(min3);  assign mt[3] = 32'(cnt3);  assign bj[3] = 32'(bj3);
    assign mc[4] = 32'(min4);  assign mt[4] = 32'(cnt4);  assign bj[4] = 32'(bj4);
    assign mc[5] = 32'(min5);  assign mt[5] = 32'(cnt5);  assign bj[5] = 32'(bj5);
    assign wv[0] = 32'(w0); assign wv[1] = 32'(w1); assign wv[2] = 32'(w2);
    assign wv[3] = 32'(w3); assign wv[4] = 32'(w4); assign wv[5] = 32'(w5);
    assign jv[0] = 32'(j0); assign jv[1] = 32'(j1); assign jv[2] = 32'(j2);
    assign jv[3] = 32'(j3); assign jv[4] = 32'(j4); assign jv[5] = 32'(j5);
    assign rdlast[0] = busy[0] && (w0 == 2'd2);
    assign rdlast[1] = busy[1] && (w1 == 2'd3);
    assign rdlast[2] = busy[2] && (w2 == 2'd3);
    assign rdlast[3] = busy[3] && (w3 == 3'd4);
    assign rdlast[4] = busy[4] && (w4 == 2'd3);
    assign rdlast[5] = busy[5] && (w5 == 1'b1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called on a negedge; returns on the negedge of the first Busy cycle.
    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, input int limit, output int lat, output int reads);
        lat   = 0;
        reads = 0;
        for (int c = 1; c <= limit; c++) begin
            if (valid[d]) begin
                lat = c;
                break;
            end
            if (rdlast[d]) reads++;
            @(negedge clk);
        end
        check($sformatf("valid_seen%0d", d), 32'(lat != 0), 32'd1);
    endtask

    task automatic check_result(input int d, input logic [31:0] emc, input logic [31:0] emt,
                                input logic [31:0] ebj);
        check($sformatf("mincost%0d", d), mc[d], emc);
        check($sformatf("matchcount%0d", d), mt[d], emt);
        check($sformatf("bestjob%0d", d), bj[d], ebj);
    endtask

    initial begin
        int lat, reads, extra, found;
        exp_id[0] = 32'h24;
        exp_id[1] = 32'hE4;
        exp_id[2] = 32'hE4;
        exp_id[3] = 32'h4688;
        exp_id[4] = 32'hE4;
        exp_id[5] = 32'h2;
        rst   = 1'b1;
        start = '0;
        mode3 = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 6; d++) begin
            check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
            check($sformatf("rst_valid%0d", d), 32'(valid[d]), 32'd0);
            check($sformatf("rst_w%0d", d), wv[d], 32'd0);
            check($sformatf("rst_j%0d", d), jv[d], 32'd0);
            check_result(d, 32'd0, 32'd0, exp_id[d]);
        end
        rst = 1'b0;
        @(negedge clk);

        // N=3, all costs 1
        pulse_start(0);
        wait_valid(0, 500, lat, reads);
        check_result(0, 32'd3, 32'd6, 32'h24);
        check("busy_at_valid", 32'(busy[0]), 32'd1);
        check("lat_n3", 32'(lat), 32'd47);
        @(negedge clk);
        check("busy_after", 32'(busy[0]), 32'd0);
        check("valid_after", 32'(valid[0]), 32'd0);

        // N=4 diagonal zero
        pulse_start(1);
        wait_valid(1, 2000, lat, reads);
        check_result(1, 32'd0, 32'd1, 32'hE4);

        // N=4 anti-diagonal zero
        pulse_start(2);
        wait_valid(2, 2000, lat, reads);
        check_result(2, 32'd0, 32'd1, 32'h1B);
`ifdef JAM_PRUNE_EN
        check("evals_n4_pruned", 32'(reads < 24), 32'd1);
`else
        check("evals_n4", 32'(reads), 32'd24);
`endif

        // N=2: permutations 01 (cost 6) and 10 (cost 2)
        pulse_start(5);
        wait_valid(5, 200, lat, reads);
        check_result(5, 32'd2, 32'd1, 32'h1);
        check("lat_n2", 32'(lat), 32'd11);
        check("evals_n2", 32'(reads), 32'd2);

        // N=5, max cost everywhere
        pulse_start(3);
        wait_valid(3, 20000, lat, reads);
        check_result(3, 32'd635, 32'd120, 32'h4688);
        check("evals_n5", 32'(reads), 32'd120);

        // 4-bit MatchCount saturates at 15 of 24 ties
        pulse_start(4);
        wait_valid(4, 2000, lat, reads);
        check_result(4, 32'd8, 32'd15, 32'hE4);

        // N=3 table with two optimal assignments (120 and 201), Start pulsed while busy
        mode3 = 1'b1;
        @(negedge clk);
        pulse_start(0);
        repeat (5) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_valid(0, 500, lat, reads);
        check_result(0, 32'd4, 32'd2, 32'h09);
`ifndef JAM_PRUNE_EN
        check("lat_ignored_start", 32'(lat), 32'd41);
`endif
        @(negedge clk);
        pulse_start(0);
        wait_valid(0, 500, lat, reads);
        check_result(0, 32'd4, 32'd2, 32'h09);
`ifndef JAM_PRUNE_EN
        check("lat_back_to_back", 32'(lat), 32'd47);
`endif
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid[0]) extra++;
        end
        check("no_extra_valid", 32'(extra), 32'd0);
        check_result(0, 32'd4, 32'd2, 32'h09);

        // Reset in the middle of a tail reversal, then rerun
        pulse_start(2);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (dut2.u_step.phase == REVERSE) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("reverse_reached", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy[2]), 32'd0);
        check("midrst_valid", 32'(valid[2]), 32'd0);
        check("midrst_w", wv[2], 32'd0);
        check("midrst_j", jv[2], 32'd0);
        check_result(2, 32'd0, 32'd0, 32'hE4);
        pulse_start(2);
        wait_valid(2, 2000, lat, reads);
        check_result(2, 32'd0, 32'd1, 32'h1B);
`ifndef JAM_PRUNE_EN
        check("evals_rerun", 32'(reads), 32'd24);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
